delay_sched: RTL and testbench
==============================

Name: delay_sched

Overview:
- Parametrised successor to the per-channel delay controller in the beamforming path.
- Sequences an external delay-calculation engine over all enabled channels for one focal point (x_f, z_f).
- Clamps each result to the delay-line range, optionally normalises delays to the minimum, then publishes all delays atomically through a double-buffered bank.
- Re-armable after completion, with a timeout guard on the engine handshake. Feeds the sample_delay array.

Parameters:
- NUM_CHANNELS, 16, number of transducer channels (≥2).
- COORD_WIDTH, 16, width of focal coordinates.
- MAX_DELAY, 256, delay-line depth; legal delays are 0..MAX_DELAY-1.
- DELAY_WIDTH, 8, delay word width; must equal $clog2(MAX_DELAY).
- TIMEOUT, 64, maximum cycles to wait for calc_done per channel.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a new focal-point computation; sampled in IDLE only
- x_f  in  COORD_WIDTH  focal x; latched on accepted start
- z_f  in  COORD_WIDTH  focal z; latched on accepted start
- ch_mask  in  NUM_CHANNELS  channel enable; bit i = channel i; latched on start
- rel_mode  in  1  1 = subtract minimum enabled delay; latched on start
- calc_start  out  1  one-cycle pulse to the delay engine
- calc_ch  out  $clog2(NUM_CHANNELS)  channel index for the engine; stable from calc_start until calc_done
- calc_x_f  out  COORD_WIDTH  latched x_f
- calc_z_f  out  COORD_WIDTH  latched z_f
- calc_done  in  1  engine result valid; single-cycle
- calc_delay  in  DELAY_WIDTH+1  engine result in samples (one extra bit for overflow)
- delay_flat  out  NUM_CHANNELS*DELAY_WIDTH  active delay bank; channel i occupies bits [(i+1)*DELAY_WIDTH-1 -: DELAY_WIDTH]
- busy  out  1  high from accepted start until return to IDLE
- ready  out  1  one-cycle pulse when a new bank is published
- clamp_flag  out  1  sticky: a result was clamped in this run
- timeout_err  out  1  sticky: the last run aborted on timeout

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; idx 0; both banks all-zero; all outputs 0 (delay_flat=0, calc_ch=0, calc_x_f/z_f=0, flags 0).
- States: IDLE, ISSUE, WAIT, STORE, NEXT, ADJUST, SWAP.
- IDLE, start=1:
  - Latch x_f, z_f, ch_mask, rel_mode; set busy.
  - Clear clamp_flag and timeout_err; clear the shadow bank to 0.
  - Set idx=0; min register = MAX_DELAY-1; go to ISSUE.
- start while busy is ignored.
- ISSUE:
  - If mask[idx]=0: no pulse; go to NEXT (1 cycle per skipped channel; its shadow entry stays 0).
  - Else: calc_start=1 for this cycle, calc_ch=idx; clear the wait counter; go to WAIT.
- WAIT:
  - calc_done=1 → STORE with result captured.
  - Counter reaches TIMEOUT without done → set timeout_err, clear busy, go to IDLE.
  - On timeout, the active bank is unchanged and ready is not pulsed.
- STORE:
  - If captured > MAX_DELAY-1: store MAX_DELAY-1 and set clamp_flag.
  - Else store the captured value into shadow[idx].
  - Update min with the stored value; go to NEXT.
- NEXT:
  - idx==NUM_CHANNELS-1 → ADJUST if rel_mode, else SWAP.
  - Otherwise idx+1 → ISSUE.
- ADJUST (1 cycle): every enabled shadow entry -= min, in parallel; disabled entries stay 0.
- Mask all-zero: no engine traffic; ADJUST is skipped regardless of rel_mode; SWAP publishes all zeros.
- SWAP: active bank <= shadow; ready=1 for this cycle; busy cleared next cycle; go to IDLE.
- delay_flat changes only on the SWAP edge; it is never partially updated.
- calc_done outside WAIT is ignored.
- start is evaluated in the cycle after SWAP, so the back-to-back minimum start-to-start interval is run length + 1.
- Latency from accepted start to ready:
  - each enabled channel = 2 + engine latency (ISSUE + WAIT cycles) + 2 (STORE, NEXT);
  - each disabled channel = 2 (ISSUE, NEXT);
  - plus 1 ADJUST (if rel_mode) and 1 SWAP.
- Reset mid-run: immediate return to IDLE; both banks zeroed; no ready pulse.

Test Plan:
- Reset, then all 16 channels enabled, engine returns delay = ch*10 after 3 cycles, rel_mode=0 → ready once, after 16*7+1=113 cycles; delay_flat channel i = 10*i; clamp_flag=0.
- Same run with rel_mode=1 and engine delay = 50+ch → published channel i = i; ADJUST cycle seen; ready at cycle 114.
- ch_mask=16'h00F0, engine returns 300 on ch5, 7 elsewhere → calc_start pulses only for ch4..7; ch5=255, clamp_flag=1; ch4/6/7=7; others 0.
- Engine never asserts calc_done on ch2 → timeout_err=1 exactly 64 WAIT cycles after ch2's calc_start; busy=0; delay_flat keeps its previous value; no ready pulse.
- start held high throughout, plus a stray calc_done during ISSUE → second run begins only after ready; stray done ignored; results match the engine values.
- Assert reset=0 mid-WAIT on ch8 → delay_flat=0, busy=0, no ready; a fresh start completes normally.

Source files
------------

// File: rtl/delay_sched.sv
// -----------------------------------------------------------------------------
// delay_sched
//
// Steps an external delay-calculation engine through every enabled transducer
// channel for one focal point (x_f, z_f). Each returned delay is clamped to
// the delay-line range. Optionally every delay is made relative to the
// smallest enabled delay. The finished set is then published in one step
// through a shadow/active double-buffered bank that feeds the sample_delay
// array.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        request a new focal-point run (honoured only when idle)
//   x_f, z_f     focal coordinates, latched on an accepted start
//   ch_mask      channel enables (bit i = channel i), latched on start
//   rel_mode     1 = subtract minimum enabled delay, latched on start
//   calc_start   one-cycle request pulse to the delay engine
//   calc_ch      channel the engine is working on (held until calc_done)
//   calc_x_f/z_f latched focal coordinates presented to the engine
//   calc_done    single-cycle engine result strobe
//   calc_delay   engine result, one extra MSB to flag overflow
//   delay_flat   active delay bank, channel i at [(i+1)*DELAY_WIDTH-1 -: DELAY_WIDTH]
//   busy         high from an accepted start until the FSM is idle again
//   ready        one-cycle pulse in the cycle a new bank becomes visible
//   clamp_flag   sticky: some result in this run was clamped
//   timeout_err  sticky: the last run was abandoned on an engine timeout
//
// DELAY_WIDTH must equal $clog2(MAX_DELAY). NUM_CHANNELS must be at least 2.
// -----------------------------------------------------------------------------
module delay_sched #(
    parameter int NUM_CHANNELS = 16,
    parameter int COORD_WIDTH  = 16,
    parameter int MAX_DELAY    = 256,
    parameter int DELAY_WIDTH  = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [COORD_WIDTH-1:0]              x_f,
    input  logic [COORD_WIDTH-1:0]              z_f,
    input  logic [NUM_CHANNELS-1:0]             ch_mask,
    input  logic                                rel_mode,
    output logic                                calc_start,
    output logic [$clog2(NUM_CHANNELS)-1:0]     calc_ch,
    output logic [COORD_WIDTH-1:0]              calc_x_f,
    output logic [COORD_WIDTH-1:0]              calc_z_f,
    input  logic                                calc_done,
    input  logic [DELAY_WIDTH:0]                calc_delay,
    output logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_flat,
    output logic                                busy,
    output logic                                ready,
    output logic                                clamp_flag,
    output logic                                timeout_err
);

    localparam int CH_W   = $clog2(NUM_CHANNELS);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int BANK_W = NUM_CHANNELS * DELAY_WIDTH;

    localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(MAX_DELAY - 1);
    localparam logic [CH_W-1:0]        LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_NEXT   = 3'd4,
        S_ADJUST = 3'd5,
        S_SWAP   = 3'd6
    } state_t;

    // Saturate a raw engine result into the legal delay-line range.
    function automatic logic [DELAY_WIDTH-1:0] clamp_delay(input logic [DELAY_WIDTH:0] raw);
        logic [DELAY_WIDTH-1:0] res;
        if (raw > {1'b0, DELAY_MAX}) begin
            res = DELAY_MAX;
        end else begin
            res = raw[DELAY_WIDTH-1:0];
        end
        return res;
    endfunction

    // Registered state
    state_t                   state_q;
    logic [CH_W-1:0]          idx_q;
    logic [CNT_W-1:0]         wait_cnt_q;
    logic [DELAY_WIDTH:0]     result_q;
    logic [DELAY_WIDTH-1:0]   min_q;
    logic [NUM_CHANNELS-1:0]  mask_q;
    logic                     rel_q;
    logic [COORD_WIDTH-1:0]   x_q;
    logic [COORD_WIDTH-1:0]   z_q;
    logic [DELAY_WIDTH-1:0]   shadow_q [NUM_CHANNELS];
    logic [BANK_W-1:0]        delay_flat_q;
    logic                     calc_start_q;
    logic                     busy_q;
    logic                     ready_q;
    logic                     clamp_q;
    logic                     timeout_q;

    // Combinational helpers
    logic [DELAY_WIDTH-1:0]   stored_s;
    logic                     clamp_hit_s;
    logic [DELAY_WIDTH-1:0]   min_next_s;
    logic [CH_W-1:0]          idx_inc_s;
    logic [DELAY_WIDTH-1:0]   adjust_s [NUM_CHANNELS];
    logic [BANK_W-1:0]        shadow_flat_s;
    logic [BANK_W-1:0]        adjust_flat_s;

    // Clamp the captured result and fold it into the running minimum.
    always_comb begin
        stored_s    = clamp_delay(result_q);
        clamp_hit_s = (result_q > {1'b0, DELAY_MAX});
        if (stored_s < min_q) begin
            min_next_s = stored_s;
        end else begin
            min_next_s = min_q;
        end
        idx_inc_s = idx_q + {{(CH_W-1){1'b0}}, 1'b1};
    end

    // Relative-mode view of the shadow bank plus packed forms for publishing.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            // Disabled entries are zero and must stay zero, so only enabled
            // entries are offset; min never exceeds any enabled entry.
            if (mask_q[i]) begin
                adjust_s[i] = shadow_q[i] - min_q;
            end else begin
                adjust_s[i] = shadow_q[i];
            end
            shadow_flat_s[i*DELAY_WIDTH +: DELAY_WIDTH] = shadow_q[i];
            adjust_flat_s[i*DELAY_WIDTH +: DELAY_WIDTH] = adjust_s[i];
        end
    end

    // Sequencer FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= {CH_W{1'b0}};
            wait_cnt_q   <= {CNT_W{1'b0}};
            result_q     <= {(DELAY_WIDTH+1){1'b0}};
            min_q        <= DELAY_MAX;
            mask_q       <= {NUM_CHANNELS{1'b0}};
            rel_q        <= 1'b0;
            x_q          <= {COORD_WIDTH{1'b0}};
            z_q          <= {COORD_WIDTH{1'b0}};
            delay_flat_q <= {BANK_W{1'b0}};
            calc_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            clamp_q      <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= {DELAY_WIDTH{1'b0}};
            end
        end else begin
            // Both pulses are asserted only on the edge entering their state.
            calc_start_q <= 1'b0;
            ready_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q          <= x_f;
                        z_q          <= z_f;
                        mask_q       <= ch_mask;
                        rel_q        <= rel_mode;
                        busy_q       <= 1'b1;
                        clamp_q      <= 1'b0;
                        timeout_q    <= 1'b0;
                        idx_q        <= {CH_W{1'b0}};
                        min_q        <= DELAY_MAX;
                        calc_start_q <= ch_mask[0];
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            shadow_q[i] <= {DELAY_WIDTH{1'b0}};
                        end
                        state_q      <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_ISSUE: begin
                    if (mask_q[idx_q]) begin
                        wait_cnt_q <= {CNT_W{1'b0}};
                        state_q    <= S_WAIT;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end

                S_WAIT: begin
                    if (calc_done) begin
                        result_q <= calc_delay;
                        state_q  <= S_STORE;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Abandon the run: the active bank is left untouched.
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q    <= S_WAIT;
                    end
                end

                S_STORE: begin
                    shadow_q[idx_q] <= stored_s;
                    min_q           <= min_next_s;
                    if (clamp_hit_s) begin
                        clamp_q <= 1'b1;
                    end else begin
                        clamp_q <= clamp_q;
                    end
                    state_q <= S_NEXT;
                end

                S_NEXT: begin
                    if (idx_q == LAST_CH) begin
                        // With nothing enabled the minimum is meaningless,
                        // so normalisation is skipped.
                        if (rel_q && (|mask_q)) begin
                            state_q <= S_ADJUST;
                        end else begin
                            delay_flat_q <= shadow_flat_s;
                            ready_q      <= 1'b1;
                            state_q      <= S_SWAP;
                        end
                    end else begin
                        idx_q        <= idx_inc_s;
                        calc_start_q <= mask_q[idx_inc_s];
                        state_q      <= S_ISSUE;
                    end
                end

                S_ADJUST: begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        shadow_q[i] <= adjust_s[i];
                    end
                    delay_flat_q <= adjust_flat_s;
                    ready_q      <= 1'b1;
                    state_q      <= S_SWAP;
                end

                S_SWAP: begin
                    // The bank became visible on the edge entering this state,
                    // together with ready; busy drops as we leave.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign calc_start  = calc_start_q;
    assign calc_ch     = idx_q;
    assign calc_x_f    = x_q;
    assign calc_z_f    = z_q;
    assign delay_flat  = delay_flat_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign clamp_flag  = clamp_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_delay_sched.sv
// -----------------------------------------------------------------------------
// tb_delay_sched
//
// Directed + randomised bench for delay_sched. A behavioural engine answers
// calc_start after a programmable latency. Expected banks, flags and cycle
// counts are computed from the channel rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_delay_sched;

    localparam int NC   = 16;
    localparam int CW   = 16;
    localparam int MAXD = 256;
    localparam int DW   = 8;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CW-1:0]     x_f;
    logic [CW-1:0]     z_f;
    logic [NC-1:0]     ch_mask;
    logic              rel_mode;
    logic              calc_start;
    logic [3:0]        calc_ch;
    logic [CW-1:0]     calc_x_f;
    logic [CW-1:0]     calc_z_f;
    logic              calc_done;
    logic [DW:0]       calc_delay;
    logic [NC*DW-1:0]  delay_flat;
    logic              busy;
    logic              ready;
    logic              clamp_flag;
    logic              timeout_err;

    // engine model controls
    logic [DW:0]       eng_val [NC];
    logic [NC-1:0]     eng_silent;
    int                eng_lat;
    logic              eng_done;
    int                eng_ch;
    logic              stray_arm;
    logic              stray_fired;
    logic              stray_done;

    logic [NC*DW-1:0]  model_bank;
    int                tests = 0;
    int                fails = 0;

    assign calc_done = eng_done | stray_done;

    always #5 clk = ~clk;

    delay_sched #(
        .NUM_CHANNELS(NC), .COORD_WIDTH(CW), .MAX_DELAY(MAXD),
        .DELAY_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .x_f(x_f), .z_f(z_f),
        .ch_mask(ch_mask), .rel_mode(rel_mode), .calc_start(calc_start),
        .calc_ch(calc_ch), .calc_x_f(calc_x_f), .calc_z_f(calc_z_f),
        .calc_done(calc_done), .calc_delay(calc_delay), .delay_flat(delay_flat),
        .busy(busy), .ready(ready), .clamp_flag(clamp_flag), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine: the request is seen in the ISSUE cycle; the result is sampled by
    // the DUT eng_lat+1 edges after the first WAIT edge.
    initial begin
        eng_done   = 1'b0;
        calc_delay = '0;
        forever begin
            @(negedge clk);
            if (calc_start === 1'b1 && reset === 1'b1) begin
                eng_ch = int'(calc_ch);
                if (!eng_silent[eng_ch]) begin
                    @(posedge clk);
                    repeat (eng_lat) @(posedge clk);
                    #1;
                    eng_done   = 1'b1;
                    calc_delay = eng_val[eng_ch];
                    @(posedge clk);
                    #1;
                    eng_done   = 1'b0;
                    calc_delay = '0;
                end
            end
        end
    end

    // Stray done: one calc_done pulse landing in an ISSUE cycle.
    initial begin
        stray_done  = 1'b0;
        stray_fired = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_arm === 1'b1 && !stray_fired && calc_start === 1'b1) begin
                stray_done  = 1'b1;
                stray_fired = 1'b1;
                @(posedge clk);
                #1;
                stray_done = 1'b0;
            end
        end
    end

    // One focal-point run: model, drive, observe, compare.
    // Entered and left at a negedge with the DUT idle (or about to restart if
    // start is held).
    task automatic run(input logic [NC-1:0] mask, input logic rel, input bit hold, input int abort_ch);
        int               vals [NC];
        int               v;
        int               mn;
        int               exp_lat;
        int               exp_nst;
        int               to_ch;
        logic             exp_clamp;
        logic [NC-1:0]    exp_starts;
        logic [NC*DW-1:0] exp_flat;
        logic [CW-1:0]    x;
        logic [CW-1:0]    z;
        int               cyc;
        int               nready;
        int               rdy_cyc;
        int               nst;
        int               st_cyc;
        int               to_cyc;
        int               ab_cyc;
        logic [NC-1:0]    starts;
        bit               fin;

        // ---- reference model ----
        to_ch = -1; exp_clamp = 1'b0; exp_starts = '0; exp_nst = 0;
        mn = MAXD - 1; exp_lat = 1;
        for (int i = 0; i < NC; i++) begin
            vals[i] = 0;
            if (mask[i]) begin
                exp_lat += eng_lat + 4;
                if (to_ch < 0) begin
                    exp_starts[i] = 1'b1;
                    exp_nst++;
                end
                if (eng_silent[i] && to_ch < 0) to_ch = i;
                v = int'(eng_val[i]);
                if (v > MAXD - 1) begin
                    v = MAXD - 1;
                    if (to_ch < 0) exp_clamp = 1'b1;
                end
                vals[i] = v;
                if (v < mn) mn = v;
            end else begin
                exp_lat += 2;
            end
        end
        if (rel && mask != '0) begin
            exp_lat++;
            for (int i = 0; i < NC; i++) if (mask[i]) vals[i] -= mn;
        end
        exp_flat = '0;
        for (int i = 0; i < NC; i++) exp_flat[i*DW +: DW] = DW'(vals[i]);

        // ---- drive ----
        x = CW'($urandom);
        z = CW'($urandom);
        start = 1'b1; x_f = x; z_f = z; ch_mask = mask; rel_mode = rel;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        x_f = ~x; z_f = ~z; ch_mask = NC'($urandom); rel_mode = ~rel;

        // ---- observe ----
        cyc = 0; nready = 0; rdy_cyc = -1; nst = 0; st_cyc = -1; to_cyc = -1;
        ab_cyc = -1; starts = '0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (calc_start === 1'b1) begin
                starts[calc_ch] = 1'b1;
                nst++;
                if (int'(calc_ch) == to_ch) st_cyc = cyc;
                if (int'(calc_ch) == abort_ch) ab_cyc = cyc;
                check("calc_xz", {calc_x_f, calc_z_f}, {x, z});
            end
            if (ready === 1'b1) begin
                nready++;
                rdy_cyc = cyc;
                check("bank_at_ready", delay_flat, exp_flat);
            end
            if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = cyc;
            if (abort_ch >= 0 && ab_cyc > 0 && cyc == ab_cyc + 2) begin
                reset = 1'b0;
                fin   = 1'b1;
            end else if (busy !== 1'b1) begin
                fin = 1'b1;
            end
        end
        check("run_bound", fin, 1'b1);

        if (abort_ch >= 0) begin
            #1;
            check("abort_flat", delay_flat, '0);
            check("abort_busy", busy, 1'b0);
            check("abort_ready", {nready[7:0], ready}, 9'd0);
            check("abort_flags", {clamp_flag, timeout_err, calc_start}, 3'b000);
            @(negedge clk);
            reset = 1'b1;
            model_bank = '0;
            repeat (10) @(negedge clk);
        end else if (to_ch >= 0) begin
            check("timeout_err", timeout_err, 1'b1);
            check("timeout_cycles", to_cyc - st_cyc, TMO + 1);
            check("timeout_no_ready", nready, 0);
            check("timeout_bank_kept", delay_flat, model_bank);
            check("timeout_busy", busy, 1'b0);
            check("timeout_starts", starts, exp_starts);
            check("timeout_clamp", clamp_flag, exp_clamp);
        end else begin
            check("ready_count", nready, 1);
            check("ready_latency", rdy_cyc, exp_lat);
            check("bank_final", delay_flat, exp_flat);
            check("clamp_flag", clamp_flag, exp_clamp);
            check("timeout_clear", timeout_err, 1'b0);
            check("start_set", starts, exp_starts);
            check("start_count", nst, exp_nst);
            check("busy_end", busy, 1'b0);
            model_bank = exp_flat;
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; x_f = '0; z_f = '0; ch_mask = '0; rel_mode = 1'b0;
        eng_lat = 3; eng_silent = '0; stray_arm = 1'b0;
        for (int i = 0; i < NC; i++) eng_val[i] = '0;
        model_bank = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_flat", delay_flat, '0);
        check("rst_ctrl", {busy, ready, calc_start, clamp_flag, timeout_err}, 5'b00000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ch_xz", {calc_ch, calc_x_f, calc_z_f}, '0);
        check("idle_ctrl", {busy, ready, calc_start, clamp_flag, timeout_err}, 5'b00000);

        // all channels, delay = 10*ch, absolute
        for (int i = 0; i < NC; i++) eng_val[i] = 9'(i * 10);
        run(16'hFFFF, 1'b0, 1'b0, -1);

        // relative mode, delay = 50+ch
        for (int i = 0; i < NC; i++) eng_val[i] = 9'(50 + i);
        run(16'hFFFF, 1'b1, 1'b0, -1);

        // sparse mask with one over-range result
        for (int i = 0; i < NC; i++) eng_val[i] = 9'd7;
        eng_val[5] = 9'd300;
        run(16'h00F0, 1'b0, 1'b0, -1);

        // engine silent on channel 2
        for (int i = 0; i < NC; i++) eng_val[i] = 9'(i + 1);
        eng_silent[2] = 1'b1;
        run(16'hFFFF, 1'b0, 1'b0, -1);
        eng_silent = '0;

        // start held high, back-to-back runs, stray done in ISSUE
        eng_lat = 2;
        for (int i = 0; i < NC; i++) eng_val[i] = 9'($urandom_range(0, 300));
        stray_arm = 1'b1;
        run(16'hA5C3, 1'b0, 1'b1, -1);
        for (int i = 0; i < NC; i++) eng_val[i] = 9'($urandom_range(0, 300));
        run(16'h3C3C, 1'b1, 1'b1, -1);
        for (int i = 0; i < NC; i++) eng_val[i] = 9'($urandom_range(0, 255));
        run(16'h0FF1, 1'b0, 1'b0, -1);
        stray_arm = 1'b0;

        // reset mid-WAIT on channel 8, then a fresh run
        eng_lat = 3;
        for (int i = 0; i < NC; i++) eng_val[i] = 9'(i + 20);
        run(16'hFFFF, 1'b0, 1'b0, 8);
        run(16'hFFFF, 1'b1, 1'b0, -1);

        // empty mask in relative mode
        run(16'h0000, 1'b1, 1'b0, -1);

        // randomised runs
        for (int r = 0; r < 6; r++) begin
            eng_lat = $urandom_range(0, 4);
            for (int i = 0; i < NC; i++) eng_val[i] = 9'($urandom_range(0, 400));
            run(NC'($urandom), 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
